// File: rtl/ex_branch_resolve_pkg.sv
// Shared decode constants and FSM encoding for the EX-stage branch resolver.
package ex_branch_resolve_pkg;

  localparam logic [6:0] JUMP_JAL  = 7'b1101111;
  localparam logic [6:0] JUMP_JALR = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [63:0] ZERO_WORD  = 64'd0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } state_e;

endpackage

// File: rtl/ex_branch_resolve_bru_cond.sv
// Branch condition evaluation for the six conditional-branch compares.
// Reserved funct3 codes resolve as not-taken.
module bru_cond
  import ex_branch_resolve_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = (rs1_i == rs2_i);
      F3_BNE:  taken_o = (rs1_i != rs2_i);
      F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: taken_o = (rs1_i <  rs2_i);
      F3_BGEU: taken_o = (rs1_i >= rs2_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// EX-stage next-PC checker: resolves the real next PC, redirects IF on a wrong
// prediction and squashes the wrong path. BRU_PERF_CNT_EN adds perf counters.
module ex_branch_resolve
  import ex_branch_resolve_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] prdt_pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [XLEN-1:0] link_data_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            squash_o,
  output logic            mispredict_o
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [63:0]     perf_branch_cnt_o,
  output logic [63:0]     perf_mispred_cnt_o
`endif
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  logic            is_jal, is_jalr, is_branch, taken, accept, mispredict;
  logic [XLEN-1:0] imm_j, imm_b, imm_i, jalr_sum, real_pc;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            redirect_q, redirect_d;
  logic            squash_q, squash_d;
  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  assign is_jal    = (inst_i[6:0] == JUMP_JAL);
  assign is_jalr   = (inst_i[6:0] == JUMP_JALR);
  assign is_branch = (inst_i[6:0] == BRANCH);

  assign imm_j = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_b = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_i = {{(XLEN-11){inst_i[31]}}, inst_i[30:20]};

  bru_cond #(.XLEN(XLEN)) u_bru_cond (
    .funct3_i (inst_i[14:12]),
    .rs1_i    (rs1_data_i),
    .rs2_i    (rs2_data_i),
    .taken_o  (taken)
  );

  assign jalr_sum    = rs1_data_i + imm_i;
  assign link_data_o = pc_i + XLEN'(4);

  always_comb begin
    real_pc = pc_i + XLEN'(4);
    if (is_jal)
      real_pc = pc_i + imm_j;
    else if (is_jalr)
      real_pc = jalr_sum & ~XLEN'(1);
    else if (is_branch && taken)
      real_pc = pc_i + imm_b;
  end

  assign accept     = valid_i & ~stall_i & (state_q == ST_IDLE);
  assign mispredict = accept & (real_pc != prdt_pc_i);

  // Outputs are registered: the *_d values describe the next cycle's state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    squash_d      = 1'b0;
    mispredict_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d       = ST_REDIRECT;
          redirect_d    = 1'b1;
          squash_d      = 1'b1;
          mispredict_d  = 1'b1;
          redirect_pc_d = real_pc;
        end
      end
      ST_REDIRECT: begin
        cnt_d = CNT_LOAD;
        if (CNT_LOAD == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_SQUASH;
          squash_d = 1'b1;
        end
      end
      ST_SQUASH: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d    = cnt_q - 3'd1;
          squash_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      redirect_q    <= 1'b0;
      squash_q      <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= XLEN'(ZERO_WORD);
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      squash_q      <= squash_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_o    = redirect_q;
  assign squash_o      = squash_q;
  assign mispredict_o  = mispredict_q;
  assign redirect_pc_o = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
  logic [63:0] perf_branch_cnt_q, perf_branch_cnt_d;
  logic [63:0] perf_mispred_cnt_q, perf_mispred_cnt_d;

  always_comb begin
    perf_branch_cnt_d  = perf_branch_cnt_q;
    perf_mispred_cnt_d = perf_mispred_cnt_q;
    if (accept && (is_jal || is_jalr || is_branch))
      perf_branch_cnt_d = perf_branch_cnt_q + 64'd1;
    if (mispredict)
      perf_mispred_cnt_d = perf_mispred_cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      perf_branch_cnt_q  <= 64'd0;
      perf_mispred_cnt_q <= 64'd0;
    end else begin
      perf_branch_cnt_q  <= perf_branch_cnt_d;
      perf_mispred_cnt_q <= perf_mispred_cnt_d;
    end
  end

  assign perf_branch_cnt_o  = perf_branch_cnt_q;
  assign perf_mispred_cnt_o = perf_mispred_cnt_q;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Scoreboard bench for ex_branch_resolve: expected redirect/target pushed at issue,
// popped and compared once the registered outputs appear.
module tb_ex_branch_resolve;

  localparam int XLEN  = 64;
  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst, valid_i, stall_i;
  logic [31:0] inst_i;
  logic [63:0] pc_i, prdt_pc_i, rs1_data_i, rs2_data_i;
  logic [63:0] link_data_o, redirect_pc_o;
  logic        redirect_o, squash_o, mispredict_o;
`ifdef BRU_PERF_CNT_EN
  logic [63:0] perf_branch_cnt_o, perf_mispred_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        redirect;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        exp;
  logic [63:0] last_pc;

  always #5 clk = ~clk;

  ex_branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .stall_i       (stall_i),
    .inst_i        (inst_i),
    .pc_i          (pc_i),
    .prdt_pc_i     (prdt_pc_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .link_data_o   (link_data_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .squash_o      (squash_o),
    .mispredict_o  (mispredict_o)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branch_cnt_o  (perf_branch_cnt_o),
    .perf_mispred_cnt_o (perf_mispred_cnt_o)
`endif
  );

  localparam logic [31:0] ALU_NOP = 32'h0000_0013;

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    valid_i = 1'b0; stall_i = 1'b0; inst_i = ALU_NOP;
    pc_i = '0; prdt_pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
  endtask

  // Drives one instruction for a cycle and records what the outputs must show afterwards.
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] prdt,
                       input logic [63:0] rs1, input logic [63:0] rs2, input logic stall,
                       input logic exp_redir, input logic [63:0] exp_pc);
    valid_i = 1'b1; stall_i = stall; inst_i = inst; pc_i = pc;
    prdt_pc_i = prdt; rs1_data_i = rs1; rs2_data_i = rs2;
    if (exp_redir) last_pc = exp_pc;
    sb_q.push_back({exp_redir, last_pc});
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic measure_squash(output int n);
    n = 0;
    while (squash_o === 1'b1 && n < 16) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (redirect_o !== 1'b0 || squash_o !== 1'b0 || mispredict_o !== 1'b0 || redirect_pc_o !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset: redirect=%b squash=%b mispred=%b pc=%h, required all zero",
               redirect_o, squash_o, mispredict_o, redirect_pc_o);
    end
    rst = 1'b0;
    last_pc = 64'h0;
    sb_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_beq_correct();
    int n;
    issue(enc_b(3'b000, 13'd16), 64'h1000, 64'h1010, 64'd5, 64'd5, 1'b0, 1'b0, 64'h0);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL beq_correct: redirect=%b pc=%h, required redirect=%b pc=%h",
               redirect_o, redirect_pc_o, exp.redirect, exp.pc);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (squash_o !== 1'b0) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("[TB] FAIL beq_no_squash: squash cycles=%0d, required 0", n);
    end
  endtask

  task automatic test_bne_mispredict();
    issue(enc_b(3'b001, 13'h1ff8), 64'h1000, 64'h1004, 64'd1, 64'd2, 1'b0, 1'b1, 64'hff8);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || mispredict_o !== 1'b1 || squash_o !== 1'b1 || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL bne_redirect: redirect=%b mispred=%b squash=%b pc=%h, required 1 1 1 pc=%h",
               redirect_o, mispredict_o, squash_o, redirect_pc_o, exp.pc);
    end
    issue(ALU_NOP, 64'h3000, 64'h9000, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || mispredict_o !== 1'b0 || squash_o !== 1'b1 || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL bne_ignored: redirect=%b mispred=%b squash=%b pc=%h, required 0 0 1 pc=%h",
               redirect_o, mispredict_o, squash_o, redirect_pc_o, exp.pc);
    end
    @(posedge clk); #1;
    checks++;
    if (squash_o !== 1'b0 || redirect_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bne_window_end: squash=%b redirect=%b, required 0 0", squash_o, redirect_o);
    end
  endtask

  task automatic test_jalr_link();
    valid_i = 1'b1; stall_i = 1'b0; inst_i = enc_jalr(12'd4); pc_i = 64'h8000;
    prdt_pc_i = 64'h2004; rs1_data_i = 64'h2001; rs2_data_i = 64'h0;
    #2;
    checks++;
    if (link_data_o !== 64'h8004) begin
      failures++;
      $display("[TB] FAIL jalr_link: link=%h, required %h", link_data_o, 64'h8004);
    end
    issue(enc_jalr(12'd4), 64'h8000, 64'h2004, 64'h2001, 64'h0, 1'b0, 1'b0, 64'h0);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || squash_o !== 1'b0 || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL jalr_target: redirect=%b squash=%b pc=%h, required 0 0 pc=%h",
               redirect_o, squash_o, redirect_pc_o, exp.pc);
    end
  endtask

  task automatic test_unsigned_signed();
    int n;
    issue(enc_b(3'b110, 13'd32), 64'h4000, 64'h4020, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h4004);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL bltu_not_taken: redirect=%b pc=%h, required redirect=%b pc=%h",
               redirect_o, redirect_pc_o, exp.redirect, exp.pc);
    end
    stall_i = 1'b1;
    measure_squash(n);
    stall_i = 1'b0;
    checks++;
    if (n != FLUSH) begin
      failures++;
      $display("[TB] FAIL squash_under_stall: squash cycles=%0d, required %0d", n, FLUSH);
    end
    issue(enc_b(3'b100, 13'd32), 64'h4000, 64'h4020, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL blt_taken: redirect=%b pc=%h, required redirect=%b pc=%h",
               redirect_o, redirect_pc_o, exp.redirect, exp.pc);
    end
  endtask

  task automatic test_jal_wrap_and_stall();
    int n;
    issue(enc_jal(21'h000800), 64'h10, 64'h810, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    issue(enc_jal(21'h000020), 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    issue(ALU_NOP, 64'h500, 64'h900, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    issue(enc_jal(21'h1FFFF0), 64'h8, 64'hC, 64'h0, 64'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    checks++;
    if (sb_q.size() != 4) begin
      failures++;
      $display("[TB] FAIL jal_sb_depth: depth=%0d, required 4", sb_q.size());
    end
    // Only the last issue is observable now; older entries fixed the expected history.
    while (sb_q.size() > 1) exp = sb_q.pop_front();
    checks++;
    if (exp.redirect !== 1'b0 || exp.pc !== 64'h4004) begin
      failures++;
      $display("[TB] FAIL jal_history: redirect=%b pc=%h, required 0 pc=%h", exp.redirect, exp.pc, 64'h4004);
    end
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL jal_wrap_redirect: redirect=%b pc=%h, required redirect=%b pc=%h",
               redirect_o, redirect_pc_o, exp.redirect, exp.pc);
    end
    measure_squash(n);
  endtask

  task automatic test_jal_correct_cycles();
    issue(enc_jal(21'h000800), 64'h10, 64'h810, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL jal_fwd: redirect=%b pc=%h, required redirect=%b pc=%h",
               redirect_o, redirect_pc_o, exp.redirect, exp.pc);
    end
    issue(ALU_NOP, 64'h500, 64'h900, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || squash_o !== 1'b0 || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL stall_ignored: redirect=%b squash=%b pc=%h, required 0 0 pc=%h",
               redirect_o, squash_o, redirect_pc_o, exp.pc);
    end
  endtask

  task automatic test_reset_mid_squash();
    issue(ALU_NOP, 64'h100, 64'h200, 64'h0, 64'h0, 1'b0, 1'b1, 64'h104);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL alu_mispredict: redirect=%b pc=%h, required redirect=%b pc=%h",
               redirect_o, redirect_pc_o, exp.redirect, exp.pc);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_pc = 64'h0;
    checks++;
    if (squash_o !== 1'b0 || redirect_o !== 1'b0 || mispredict_o !== 1'b0 || redirect_pc_o !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_squash: squash=%b redirect=%b mispred=%b pc=%h, required all zero",
               squash_o, redirect_o, mispredict_o, redirect_pc_o);
    end
    issue(ALU_NOP, 64'h300, 64'h500, 64'h0, 64'h0, 1'b0, 1'b1, 64'h304);
    exp = sb_q.pop_front();
    checks++;
    if (redirect_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
      failures++;
      $display("[TB] FAIL post_reset_accept: redirect=%b pc=%h, required redirect=%b pc=%h",
               redirect_o, redirect_pc_o, exp.redirect, exp.pc);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [63:0] pool [5];
    logic [63:0] pc, rs1, rs2, target, prdt;
    logic [31:0] inst;
    logic [12:0] bimm;
    logic [20:0] jimm;
    logic [11:0] iimm;
    logic [2:0]  f3;
    int          n;
    pool[0] = 64'h0; pool[1] = 64'h1; pool[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    pool[3] = 64'h8000_0000_0000_0000; pool[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      pc  = {$urandom, $urandom} & ~64'h3;
      rs1 = pool[$urandom_range(0, 4)];
      rs2 = pool[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0: begin
          f3 = 3'($urandom_range(0, 7));
          bimm = 13'($urandom) & 13'h1FFE;
          inst = enc_b(f3, bimm);
          target = ref_taken(f3, rs1, rs2) ? pc + {{51{bimm[12]}}, bimm} : pc + 64'd4;
        end
        1: begin
          jimm = 21'($urandom) & 21'h1FFFFE;
          inst = enc_jal(jimm);
          target = pc + {{43{jimm[20]}}, jimm};
        end
        2: begin
          iimm = 12'($urandom);
          inst = enc_jalr(iimm);
          target = (rs1 + {{52{iimm[11]}}, iimm}) & ~64'h1;
        end
        default: begin
          inst = ALU_NOP;
          target = pc + 64'd4;
        end
      endcase
      prdt = ($urandom_range(0, 1) == 1) ? target : target ^ 64'h40;
      issue(inst, pc, prdt, rs1, rs2, 1'b0, prdt != target, target);
      exp = sb_q.pop_front();
      checks++;
      if (redirect_o !== exp.redirect || mispredict_o !== exp.redirect || redirect_pc_o !== exp.pc) begin
        failures++;
        $display("[TB] FAIL random_%0d: redirect=%b mispred=%b pc=%h, required redirect=%b pc=%h",
                 i, redirect_o, mispredict_o, redirect_pc_o, exp.redirect, exp.pc);
      end
      if (exp.redirect) begin
        measure_squash(n);
        checks++;
        if (n != FLUSH) begin
          failures++;
          $display("[TB] FAIL random_squash_%0d: squash cycles=%0d, required %0d", i, n, FLUSH);
        end
      end
    end
  endtask

`ifdef BRU_PERF_CNT_EN
  task automatic test_perf_counters();
    int n;
    test_reset();
    issue(enc_b(3'b000, 13'd16), 64'h1000, 64'h1010, 64'd5, 64'd5, 1'b0, 1'b0, 64'h0);
    issue(enc_b(3'b001, 13'd16), 64'h1010, 64'h1014, 64'd5, 64'd5, 1'b0, 1'b0, 64'h0);
    issue(enc_jal(21'h000100), 64'h2000, 64'h2004, 64'h0, 64'h0, 1'b0, 1'b1, 64'h2100);
    measure_squash(n);
    issue(ALU_NOP, 64'h3000, 64'h3004, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    issue(ALU_NOP, 64'h3004, 64'h3008, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    sb_q.delete();
    checks++;
    if (perf_branch_cnt_o !== 64'd3 || perf_mispred_cnt_o !== 64'd1) begin
      failures++;
      $display("[TB] FAIL perf_counts: branch=%0d mispred=%0d, required 3 1",
               perf_branch_cnt_o, perf_mispred_cnt_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_beq_correct();
    test_bne_mispredict();
    test_jalr_link();
    test_unsigned_signed();
    test_jal_correct_cycles();
    test_jal_wrap_and_stall();
    test_reset_mid_squash();
    test_random();
`ifdef BRU_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
